// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Streams RGB444 pixels in raster order and emits the 3x3 neighbourhood of
//   every interior pixel, one clock after the pixel that completes it.
//
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    synchronous, active-high
//   pix_in       in   12   RGB444 pixel {R[11:8], G[7:4], B[3:0]}
//   pix_valid    in   1    pix_in accepted this cycle (no backpressure)
//   pix_sof      in   1    first pixel of a frame (qualified by pix_valid)
//   window_out   out  108  {c, l, r, u, d, ul, ur, dl, dr}, 12 bits each
//   window_valid out  1    one-cycle pulse per emitted window
//   frame_done   out  1    one-cycle pulse after the last pixel of a frame
//   sof_err      out  1    one-cycle pulse when a frame restarts early
//
// state    | meaning
// ---------+---------------------------------------------------------
// WAIT_SOF | idle; pixels without pix_sof are dropped
// ACTIVE   | inside a frame; row_q/col_q give the next pixel position

module window_gen_3x3 #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [11:0]  pix_in,
   input  logic         pix_valid,
   input  logic         pix_sof,
   output logic [107:0] window_out,
   output logic         window_valid,
   output logic         frame_done,
   output logic         sof_err
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   // Column vectors {row r-2, row r-1, row r} for columns c-1 and c-2.
   logic [35:0]     col_m1_q, col_m1_d;
   logic [35:0]     col_m2_q, col_m2_d;
   logic [107:0]    window_q, window_d;
   logic            window_valid_q, window_valid_d;
   logic            frame_done_q, frame_done_d;
   logic            sof_err_q, sof_err_d;

   // Line buffers hold rows r-1 and r-2; never reset, always written before read.
   logic [11:0]     line_buf1_q [IMG_WIDTH];
   logic [11:0]     line_buf2_q [IMG_WIDTH];

   logic            accept;
   logic [RW-1:0]   pix_row;
   logic [CW-1:0]   pix_col;
   logic [35:0]     cur_vec;

   // A pix_sof always places the current pixel at (0,0), whatever the state.
   assign accept  = pix_valid && ((state_q == ACTIVE) || pix_sof);
   assign pix_row = pix_sof ? '0 : row_q;
   assign pix_col = pix_sof ? '0 : col_q;
   assign cur_vec = {line_buf2_q[pix_col], line_buf1_q[pix_col], pix_in};

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      col_d          = col_q;
      col_m1_d       = col_m1_q;
      col_m2_d       = col_m2_q;
      window_d       = window_q;
      window_valid_d = 1'b0;
      frame_done_d   = 1'b0;
      sof_err_d      = 1'b0;

      if (accept) begin
         sof_err_d = pix_sof && (state_q == ACTIVE);
         state_d   = ACTIVE;
         col_m1_d  = cur_vec;
         col_m2_d  = col_m1_q;

         // Rows 0..1 and cols 0..1 of a frame cannot complete a window, which
         // also guarantees every tap comes from the current frame.
         if ((pix_row >= RW'(2)) && (pix_col >= CW'(2))) begin
            window_valid_d = 1'b1;
            window_d = {col_m1_q[23:12],   // center
                        col_m2_q[23:12],   // left
                        cur_vec[23:12],    // right
                        col_m1_q[35:24],   // up
                        col_m1_q[11:0],    // down
                        col_m2_q[35:24],   // upleft
                        cur_vec[35:24],    // upright
                        col_m2_q[11:0],    // downleft
                        cur_vec[11:0]};    // downright
         end

         if (pix_col == COL_LAST) begin
            col_d = '0;
            if (pix_row == ROW_LAST) begin
               row_d        = '0;
               state_d      = WAIT_SOF;
               frame_done_d = 1'b1;
            end else begin
               row_d = pix_row + RW'(1);
            end
         end else begin
            col_d = pix_col + CW'(1);
            row_d = pix_row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= WAIT_SOF;
         row_q          <= '0;
         col_q          <= '0;
         col_m1_q       <= '0;
         col_m2_q       <= '0;
         window_q       <= '0;
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         sof_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         col_q          <= col_d;
         col_m1_q       <= col_m1_d;
         col_m2_q       <= col_m2_d;
         window_q       <= window_d;
         window_valid_q <= window_valid_d;
         frame_done_q   <= frame_done_d;
         sof_err_q      <= sof_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         line_buf2_q[pix_col] <= line_buf1_q[pix_col];
         line_buf1_q[pix_col] <= pix_in;
      end
   end

   assign window_out   = window_q;
   assign window_valid = window_valid_q;
   assign frame_done   = frame_done_q;
   assign sof_err      = sof_err_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Testbench for window_gen_3x3 with a 4x4 image, pixel(r,c) = base + r*16 + c.
// A reference model tracks frame position in a 2-D image array and pushes the
// expected window into a queue when a pixel is driven; the queue is popped
// whenever the DUT raises window_valid.

module tb_window_gen_3x3;

   localparam int W = 4;
   localparam int H = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [11:0]  pix_in;
   logic         pix_valid;
   logic         pix_sof;
   logic [107:0] window_out;
   logic         window_valid;
   logic         frame_done;
   logic         sof_err;

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk          (clk),
      .reset        (reset),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_sof      (pix_sof),
      .window_out   (window_out),
      .window_valid (window_valid),
      .frame_done   (frame_done),
      .sof_err      (sof_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state
   logic [11:0]  mimg [H][W];
   logic [107:0] win_q [$];
   logic         m_active = 1'b0;
   int           mrow = 0;
   int           mcol = 0;
   logic         exp_wv = 1'b0;
   logic         exp_fd = 1'b0;
   logic         exp_se = 1'b0;
   logic [107:0] last_win = '0;

   // Per-test observation counters
   int           win_cnt;
   int           fd_cnt;
   int           se_cnt;
   logic [107:0] first_win;

   task automatic chk(input string tag, input logic [107:0] got, input logic [107:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [107:0] mk_win(input int r, input int c);
      return {mimg[r][c],     mimg[r][c-1],   mimg[r][c+1],
              mimg[r-1][c],   mimg[r+1][c],   mimg[r-1][c-1],
              mimg[r-1][c+1], mimg[r+1][c-1], mimg[r+1][c+1]};
   endfunction

   task automatic model_step(input logic v, input logic s, input logic [11:0] p, input logic rst);
      int r;
      int c;
      exp_wv = 1'b0;
      exp_fd = 1'b0;
      exp_se = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         mrow     = 0;
         mcol     = 0;
         last_win = '0;
         win_q.delete();
      end else if (v && (m_active || s)) begin
         if (s) begin
            exp_se = m_active;
            r = 0;
            c = 0;
         end else begin
            r = mrow;
            c = mcol;
         end
         mimg[r][c] = p;
         if (r >= 2 && c >= 2) begin
            win_q.push_back(mk_win(r - 1, c - 1));
            exp_wv = 1'b1;
         end
         m_active = 1'b1;
         if (c == W - 1) begin
            mcol = 0;
            if (r == H - 1) begin
               mrow     = 0;
               m_active = 1'b0;
               exp_fd   = 1'b1;
            end else begin
               mrow = r + 1;
            end
         end else begin
            mcol = c + 1;
            mrow = r;
         end
      end
   endtask

   task automatic cycle(input logic v, input logic s, input logic [11:0] p, input logic rst);
      logic [107:0] exp_w;
      reset     = rst;
      pix_valid = v;
      pix_sof   = s;
      pix_in    = p;
      @(posedge clk);
      model_step(v, s, p, rst);
      #1;
      chk("window_valid", 108'(window_valid), 108'(exp_wv));
      chk("frame_done",   108'(frame_done),   108'(exp_fd));
      chk("sof_err",      108'(sof_err),      108'(exp_se));
      if (window_valid) begin
         if (win_cnt == 0) first_win = window_out;
         win_cnt++;
         if (win_q.size() == 0) begin
            chk("unexpected_window", 108'(1), 108'(0));
         end else begin
            exp_w = win_q.pop_front();
            chk("window_out", window_out, exp_w);
            last_win = exp_w;
         end
      end else begin
         chk("window_hold", window_out, last_win);
      end
      if (frame_done) begin
         fd_cnt++;
         chk("fd_with_last_window", 108'(window_valid), 108'(1));
      end
      if (sof_err) se_cnt++;
   endtask

   task automatic send_pixels(input logic [11:0] base, input int npix, input logic gaps);
      for (int i = 0; i < npix; i++) begin
         cycle(1'b1, i == 0, base + 12'(((i / W) * 16) + (i % W)), 1'b0);
         if (gaps) cycle(1'b0, 1'b0, 12'h000, 1'b0);
      end
   endtask

   task automatic clear_counts();
      win_cnt   = 0;
      fd_cnt    = 0;
      se_cnt    = 0;
      first_win = '0;
   endtask

   localparam logic [107:0] GOLDEN_FIRST =
      108'h011_010_012_001_021_000_002_020_022;

   initial begin
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_in    = '0;
      clear_counts();

      // Reset state
      cycle(1'b0, 1'b0, 12'h000, 1'b1);
      cycle(1'b0, 1'b0, 12'h000, 1'b1);
      chk("reset_window_out", window_out, 108'(0));
      cycle(1'b0, 1'b0, 12'h000, 1'b0);

      // Full frame, continuous valid
      clear_counts();
      send_pixels(12'h000, W * H, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      chk("t1_windows", 108'(win_cnt), 108'(4));
      chk("t1_frame_done", 108'(fd_cnt), 108'(1));
      chk("t1_first_window", first_win, GOLDEN_FIRST);

      // Same frame, valid toggling
      clear_counts();
      send_pixels(12'h000, W * H, 1'b1);
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      chk("t2_windows", 108'(win_cnt), 108'(4));
      chk("t2_frame_done", 108'(fd_cnt), 108'(1));
      chk("t2_first_window", first_win, GOLDEN_FIRST);

      // Pixels before any sof, plus sof without valid, then a frame
      clear_counts();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 12'hABC + 12'(i), 1'b0);
      cycle(1'b0, 1'b1, 12'h777, 1'b0);
      chk("t3_no_early_windows", 108'(win_cnt), 108'(0));
      send_pixels(12'h000, W * H, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      chk("t3_windows", 108'(win_cnt), 108'(4));
      chk("t3_first_window", first_win, GOLDEN_FIRST);

      // Early sof at pixel (2,1) of a partial frame
      clear_counts();
      send_pixels(12'h500, 2 * W + 1, 1'b0);
      send_pixels(12'h000, W * H, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      chk("t4_sof_err", 108'(se_cnt), 108'(1));
      chk("t4_windows", 108'(win_cnt), 108'(4));
      chk("t4_first_window", first_win, GOLDEN_FIRST);

      // Reset after pixel (2,2)
      clear_counts();
      send_pixels(12'h300, 2 * W + 3, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b1);
      chk("t5_reset_window_out", window_out, 108'(0));
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      clear_counts();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 12'h3F0, 1'b0);
      send_pixels(12'h000, W * H, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      chk("t5_windows", 108'(win_cnt), 108'(4));
      chk("t5_first_window", first_win, GOLDEN_FIRST);

      // Back-to-back frames
      clear_counts();
      send_pixels(12'h000, W * H, 1'b0);
      send_pixels(12'h100, W * H, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b0);
      chk("t6_windows", 108'(win_cnt), 108'(8));
      chk("t6_frame_done", 108'(fd_cnt), 108'(2));
      chk("t6_sof_err", 108'(se_cnt), 108'(0));

      chk("queue_drained", 108'(win_q.size()), 108'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
